// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//
// Watches CHANNELS synchronous level lines for qualified rising/falling edges.
// Each qualified edge is held as a pending event with its polarity. Pending
// events go out one at a time, round-robin, to a single consumer over a
// valid/ready handshake. While the consumer stalls, a repeated edge on a
// channel that is already pending replaces the stored polarity.
//
// Optional feature macro: EDGE_EVENT_ARBITER_OVERFLOW_EN
//   defined     -> per-channel sticky overflow flags record overwritten events
//   not defined -> overflow is tied to zero and no flag registers are built
//
// Reset is synchronous and active-low (reset_low), sampled on posedge clk.
// -----------------------------------------------------------------------------
module edge_event_arbiter #(
  parameter int                  CHANNELS  = 4,
  parameter logic [CHANNELS-1:0] RISE_MASK = {CHANNELS{1'b1}},
  parameter logic [CHANNELS-1:0] FALL_MASK = {CHANNELS{1'b0}}
) (
  input  logic                        clk,
  input  logic                        reset_low,
  input  logic [CHANNELS-1:0]         level,
  output logic                        event_valid,
  input  logic                        event_ready,
  output logic [$clog2(CHANNELS)-1:0] event_channel,
  output logic                        event_rising,
  output logic [CHANNELS-1:0]         overflow
);

  localparam int CW = $clog2(CHANNELS);

  // Output FSM encoding.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  // Reject channel counts the round-robin search and index width cannot serve.
  if (CHANNELS < 2 || CHANNELS > 32) begin : g_bad_channels
    $error("edge_event_arbiter: CHANNELS must be within 2..32");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] previous;        // level one cycle ago
  logic [CHANNELS-1:0] pending;         // channel has an undelivered event
  logic [CHANNELS-1:0] pending_rising;  // polarity of the newest pending edge
  logic [0:0]          state;
  logic [CW-1:0]       last;            // most recently granted channel

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] rise_q;       // qualified rising edges this cycle
  logic [CHANNELS-1:0] fall_q;       // qualified falling edges this cycle
  logic [CHANNELS-1:0] edge_q;       // any qualified edge this cycle
  logic                handshake;    // offered event is accepted at this edge
  logic                any_pending;
  logic                load;         // a new selection is loaded at this edge
  logic [CW-1:0]       sel;          // round-robin winner among pending
  logic                found;
  logic [CW-1:0]       cand;
  int                  idx;
  logic [CHANNELS-1:0] clear_mask;   // pending bit consumed by this load

  assign rise_q      = level & ~previous & RISE_MASK;
  assign fall_q      = ~level & previous & FALL_MASK;
  assign edge_q      = rise_q | fall_q;
  assign event_valid = (state == ST_OFFER);
  assign handshake   = event_valid & event_ready;
  assign any_pending = |pending;

  // A load happens whenever something is pending and the output slot is free,
  // either because nothing is offered or because the offer is being accepted.
  assign load = any_pending & (~event_valid | handshake);

  // Round-robin search: first pending channel after last, wrapping to 0.
  always_comb begin : rr_select
    // NOTE: every variable written here gets a default first, so no path
    // leaves it holding its old value and no latch is inferred.
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = int'(last) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      cand = CW'(idx);
      if (!found && pending[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // One-hot mask of the pending bit taken by this cycle's load.
  always_comb begin : clear_decode
    clear_mask = '0;
    if (load) clear_mask[sel] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Edge detection history
  // ---------------------------------------------------------------------------
  // Remember last cycle's levels so edges can be seen this cycle.
  always_ff @(posedge clk) begin : prev_reg
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    if (!reset_low) previous <= '0;
    else            previous <= level;
  end

  // ---------------------------------------------------------------------------
  // Pending events and their polarity
  // ---------------------------------------------------------------------------
  // A new edge always (re)sets pending, even on the bit a load is clearing, so
  // an edge arriving as its channel is granted becomes a separate later event.
  always_ff @(posedge clk) begin : pending_reg
    if (!reset_low) begin
      pending        <= '0;
      pending_rising <= '0;
    end else begin
      pending        <= (pending & ~clear_mask) | edge_q;
      pending_rising <= (pending_rising & ~edge_q) | rise_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FSM and round-robin pointer
  // ---------------------------------------------------------------------------
  // Offer holds channel/polarity stable until accepted; back-to-back loads
  // keep the FSM in OFFER so a ready consumer sees one event per cycle.
  always_ff @(posedge clk) begin : offer_fsm
    if (!reset_low) begin
      state         <= ST_IDLE;
      event_channel <= '0;
      event_rising  <= 1'b0;
      last          <= CW'(CHANNELS - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state         <= ST_OFFER;
            event_channel <= sel;
            event_rising  <= pending_rising[sel];
            last          <= sel;
          end
        end
        ST_OFFER: begin
          if (load) begin
            event_channel <= sel;
            event_rising  <= pending_rising[sel];
            last          <= sel;
          end else if (handshake) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow tracking
  // ---------------------------------------------------------------------------
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
  logic [CHANNELS-1:0] overwrite;    // edge replaced a still-pending event
  logic [CHANNELS-1:0] accept_mask;  // channel whose offer is accepted now
  logic [CHANNELS-1:0] overflow_q;

  // An edge on a bit being cleared by this load is a fresh event, not a loss.
  assign overwrite = edge_q & pending & ~clear_mask;

  always_comb begin : accept_decode
    accept_mask = '0;
    if (handshake) accept_mask[event_channel] = 1'b1;
  end

  // Sticky loss flag: a same-cycle overwrite wins over the acceptance clear.
  always_ff @(posedge clk) begin : overflow_reg
    if (!reset_low) overflow_q <= '0;
    else            overflow_q <= (overflow_q & ~accept_mask) | overwrite;
  end

  assign overflow = overflow_q;
`else
  assign overflow = '0;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_edge_event_arbiter
//
// Directed bench for edge_event_arbiter (4 channels, all rising edges enabled,
// falling edges enabled on channels 1 and 2). A queue-free behavioural model
// tracks the pending set, stored polarity, the current offer and the grant
// pointer from the block's rules; a compare process checks the DUT against it
// on every negative edge. Literal expectations at fixed points pin the model.
// Honours EDGE_EVENT_ARBITER_OVERFLOW_EN for the expected overflow flags.
// -----------------------------------------------------------------------------
module tb_edge_event_arbiter;

  localparam int             NCH   = 4;
  localparam logic [NCH-1:0] RMASK = 4'b1111;
  localparam logic [NCH-1:0] FMASK = 4'b0110;
`ifdef EDGE_EVENT_ARBITER_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_low;
  logic [NCH-1:0] level;
  logic           event_valid;
  logic           event_ready;
  logic [1:0]     event_channel;
  logic           event_rising;
  logic [NCH-1:0] overflow;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  edge_event_arbiter #(
    .CHANNELS (NCH),
    .RISE_MASK(RMASK),
    .FALL_MASK(FMASK)
  ) dut (
    .clk          (clk),
    .reset_low    (reset_low),
    .level        (level),
    .event_valid  (event_valid),
    .event_ready  (event_ready),
    .event_channel(event_channel),
    .event_rising (event_rising),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: sets of pending channels and the single offer slot.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] m_prev  = '0;
  logic [NCH-1:0] m_pend  = '0;
  logic [NCH-1:0] m_prise = '0;
  logic [NCH-1:0] m_ovf   = '0;
  logic           m_valid = 1'b0;
  logic           m_rise  = 1'b0;
  int             m_chan  = 0;
  int             m_last  = NCH - 1;

  task automatic model_step();
    logic [NCH-1:0] is_edge, is_rise, lost;
    logic           hs;
    int             pick, c;
    if (!reset_low) begin
      m_prev  = '0;
      m_pend  = '0;
      m_prise = '0;
      m_ovf   = '0;
      m_valid = 1'b0;
      m_rise  = 1'b0;
      m_chan  = 0;
      m_last  = NCH - 1;
    end else begin
      hs   = m_valid && event_ready;
      pick = -1;
      if (!m_valid || hs) begin
        for (int k = 1; k <= NCH; k++) begin
          c = (m_last + k) % NCH;
          if (pick < 0 && m_pend[c]) pick = c;
        end
      end
      lost = '0;
      for (int i = 0; i < NCH; i++) begin
        is_rise[i] = level[i] && !m_prev[i] && RMASK[i];
        is_edge[i] = is_rise[i] || (!level[i] && m_prev[i] && FMASK[i]);
        if (is_edge[i] && m_pend[i] && i != pick) lost[i] = 1'b1;
      end
      if (hs && !lost[m_chan]) m_ovf[m_chan] = 1'b0;
      m_ovf = m_ovf | lost;
      if (pick >= 0) begin
        m_chan       = pick;
        m_rise       = m_prise[pick];
        m_pend[pick] = 1'b0;
        m_last       = pick;
        m_valid      = 1'b1;
      end else if (hs) begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (is_edge[i]) begin
          m_pend[i]  = 1'b1;
          m_prise[i] = is_rise[i];
        end
      end
      m_prev = level;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (started) begin
      check("cmp_valid", 32'(event_valid), 32'(m_valid));
      if (m_valid) begin
        check("cmp_channel", 32'(event_channel), m_chan);
        check("cmp_rising", 32'(event_rising), 32'(m_rise));
      end
      check("cmp_overflow", 32'(overflow), OVF_EN ? 32'(m_ovf) : 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  initial begin
    reset_low   = 1'b0;
    level       = '0;
    event_ready = 1'b0;
    step();
    step();
    started = 1'b1;
    check("rst_valid", 32'(event_valid), 0);
    check("rst_channel", 32'(event_channel), 0);
    check("rst_rising", 32'(event_rising), 0);
    check("rst_overflow", 32'(overflow), 0);
    reset_low = 1'b1;
    step();

    // Single rising edge on channel 0: valid two cycles later, then accepted.
    level[0] = 1'b1;
    step();
    check("t1_not_yet", 32'(event_valid), 0);
    step();
    check("t1_valid", 32'(event_valid), 1);
    check("t1_channel", 32'(event_channel), 0);
    check("t1_rising", 32'(event_rising), 1);
    event_ready = 1'b1;
    step();
    check("t1_drop", 32'(event_valid), 0);
    event_ready = 1'b0;

    // Channels 3,1,2 together: grants 1,2,3 back-to-back once ready is high.
    level[3:1] = 3'b111;
    step();
    step();
    check("t2_first", 32'(event_channel), 1);
    check("t2_first_v", 32'(event_valid), 1);
    event_ready = 1'b1;
    step();
    check("t2_second", 32'(event_channel), 2);
    step();
    check("t2_third", 32'(event_channel), 3);
    check("t2_third_v", 32'(event_valid), 1);
    step();
    check("t2_drop", 32'(event_valid), 0);

    // Fall channels 2 and 3: only channel 2 has falling edges enabled.
    level[3:2] = 2'b00;
    step();
    step();
    check("t2b_channel", 32'(event_channel), 2);
    check("t2b_rising", 32'(event_rising), 0);
    step();
    check("t2b_drop", 32'(event_valid), 0);

    // Fall channel 1 -> event; fall channel 0 -> nothing.
    level[1] = 1'b0;
    step();
    step();
    check("t3_channel", 32'(event_channel), 1);
    check("t3_rising", 32'(event_rising), 0);
    step();
    check("t3_drop", 32'(event_valid), 0);
    level[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_no_fall0", 32'(event_valid), 0);
    end

    // Stall on channel 0 while channel 2 toggles 0->1->0: one falling event.
    event_ready = 1'b0;
    level[0] = 1'b1;
    step();
    step();
    check("t4_hold_ch", 32'(event_channel), 0);
    level[2] = 1'b1;
    step();
    level[2] = 1'b0;
    step();
    check("t4_ovf2", 32'(overflow[2]), 32'(OVF_EN));
    check("t4_still_ch0", 32'(event_channel), 0);
    event_ready = 1'b1;
    step();
    check("t4_ch2", 32'(event_channel), 2);
    check("t4_ch2_rise", 32'(event_rising), 0);
    check("t4_ovf2_kept", 32'(overflow[2]), 32'(OVF_EN));
    step();
    check("t4_one_event", 32'(event_valid), 0);
    check("t4_ovf2_clr", 32'(overflow[2]), 0);

    // Stall on channel 1 for 10 cycles while other channels see edges.
    event_ready = 1'b0;
    level[1] = 1'b1;
    step();
    step();
    check("t5_ch1", 32'(event_channel), 1);
    for (int k = 1; k <= 10; k++) begin
      case (k)
        1: level[3] = 1'b1;
        3: level[2] = 1'b1;
        5: level[3] = 1'b0;
        6: level[3] = 1'b1;
        7: level[0] = 1'b0;
        8: level[0] = 1'b1;
        default: ;
      endcase
      step();
      check("t5_stall_valid", 32'(event_valid), 1);
      check("t5_stall_ch", 32'(event_channel), 1);
      check("t5_stall_rise", 32'(event_rising), 1);
    end
    check("t5_ovf", 32'(overflow), OVF_EN ? 32'h8 : 32'h0);

    // Reset during an offer with channels 0, 2, 3 pending: all discarded.
    reset_low = 1'b0;
    level     = '0;
    step();
    check("t6_rst_valid", 32'(event_valid), 0);
    check("t6_rst_ovf", 32'(overflow), 0);
    reset_low = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_quiet", 32'(event_valid), 0);
    end

    // Levels held high across reset release: rising edges, channel 0 first.
    reset_low = 1'b0;
    level     = 4'b1001;
    step();
    reset_low = 1'b1;
    step();
    check("t7_not_yet", 32'(event_valid), 0);
    step();
    check("t7_ch0", 32'(event_channel), 0);
    check("t7_ch0_rise", 32'(event_rising), 1);
    event_ready = 1'b1;
    step();
    check("t7_ch3", 32'(event_channel), 3);
    step();
    check("t7_drop", 32'(event_valid), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
